piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, a per-bit shift-enable stall and a selectable bit order.
- Sits between a parallel word producer and a serial link or bit-banged peripheral.
- Supports back-to-back words with no idle bit slot between them.
- A serial input allows several instances to be chained.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_serializer_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 100 ++++++++++
 tb/tb_piso_serializer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
package piso_pkg;

    // Serializer control states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-order selectors for the MSB_FIRST parameter
    localparam int ORDER_MSB = 1;
    localparam int ORDER_LSB = 0;

    // Width of a counter that must reach WIDTH-1
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module bit_counter
    import piso_pkg::*;
#(
    parameter int CNT_W = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    // Count up on enable, stop at MAX; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == MAX_C);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load, shift stall
// and selectable bit order. Words can stream back to back without a gap.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic FILL      = 1'b0,
    parameter int   CASCADE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             tc;
    logic             in_shift;
    logic             end_of_word;
    logic             load_fire;
    logic             fill_bit;
    logic             out_bit;

    assign in_shift    = (state == SHIFT);
    assign end_of_word = in_shift && tc && shift_en;
    // Ready is combinational on shift_en so the next word can load on the
    // same edge that retires the last bit of the current one.
    assign load_ready  = !rst && (!in_shift || end_of_word);
    assign load_fire   = load_valid && load_ready;

    assign fill_bit = (CASCADE != 0) ? sin : FILL;
    assign out_bit  = (MSB_FIRST == ORDER_MSB) ? shreg[WIDTH-1] : shreg[0];

    assign sout       = in_shift && out_bit;
    assign sout_valid = in_shift;
    assign busy       = in_shift;
    assign last       = in_shift && (bit_cnt == LAST_CNT);

    // Cleared on every load and at end of word so it idles at zero
    bit_counter #(
        .CNT_W (CNT_W),
        .MAX   (WIDTH - 1)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (load_fire || end_of_word),
        .en  (in_shift && shift_en),
        .cnt (bit_cnt),
        .tc  (tc)
    );

    // Next shift-register value: move toward the output end, refill the other
    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST == ORDER_MSB) begin
            shreg_next = {shreg[WIDTH-2:0], fill_bit};
        end else begin
            shreg_next = {fill_bit, shreg[WIDTH-1:1]};
        end
    end

    // Shift register: load on handshake, shift on enable while a word is live
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load_fire) begin
            shreg <= par_in;
        end else if (in_shift && shift_en) begin
            shreg <= shreg_next;
        end
    end

    // Control FSM: stay in SHIFT across back-to-back words
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load_fire) state <= SHIFT;
                SHIFT:   if (end_of_word) state <= load_valid ? SHIFT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB-first, LSB-first,
// MSB-first cascaded with sin) share stimulus and are checked every cycle.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst, load_valid, shift_en, sin;
    logic [7:0] par_in;

    logic lr_m, so_m, sv_m, la_m, bz_m;
    logic lr_l, so_l, sv_l, la_l, bz_l;
    logic lr_c, so_c, sv_c, la_c, bz_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .FILL(1'b0), .CASCADE(0)) dut_m (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid), .load_ready(lr_m),
        .shift_en(shift_en), .sin(sin), .sout(so_m), .sout_valid(sv_m), .last(la_m), .busy(bz_m));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .FILL(1'b0), .CASCADE(0)) dut_l (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid), .load_ready(lr_l),
        .shift_en(shift_en), .sin(sin), .sout(so_l), .sout_valid(sv_l), .last(la_l), .busy(bz_l));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .FILL(1'b0), .CASCADE(1)) dut_c (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid), .load_ready(lr_c),
        .shift_en(shift_en), .sin(sin), .sout(so_c), .sout_valid(sv_c), .last(la_c), .busy(bz_c));

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_m;   // MSB-first stream, first bit in [7]
        logic [7:0] exp_l;   // LSB-first stream, first bit in [7]
        int         stall_bit;
        int         stall_len;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Fields compared: {sout, sout_valid, last, busy, load_ready}
    task automatic sample(input string tag, input logic e_m, input logic e_l,
                          input logic ev, input logic el, input logic er);
        chk({tag, " msb"},  {3'b0, so_m, sv_m, la_m, bz_m, lr_m}, {3'b0, e_m, ev, el, ev, er});
        chk({tag, " lsb"},  {3'b0, so_l, sv_l, la_l, bz_l, lr_l}, {3'b0, e_l, ev, el, ev, er});
        chk({tag, " casc"}, {3'b0, so_c, sv_c, la_c, bz_c, lr_c}, {3'b0, e_m, ev, el, ev, er});
    endtask

    task automatic drive(input logic r, input logic lv, input logic se, input logic [7:0] p);
        @(negedge clk);
        rst        = r;
        load_valid = lv;
        shift_en   = se;
        par_in     = p;
        #1;
    endtask

    task automatic send_word(input int k);
        vec_t v;
        logic em, el, lst;
        v = tbl[k];
        drive(1'b0, 1'b1, 1'b0, v.word);
        sample("load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            em  = v.exp_m[7-i];
            el  = v.exp_l[7-i];
            lst = (i == 7);
            if (i == v.stall_bit) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    // A competing request during the stall must be refused
                    drive(1'b0, 1'b1, 1'b0, ~v.word);
                    sample("stall", em, el, 1'b1, lst, 1'b0);
                end
            end
            drive(1'b0, 1'b0, 1'b1, v.word);
            sample("bit", em, el, 1'b1, lst, lst);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        sample("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("casc shreg", dut_c.shreg, 8'hFF);
        chk("msb shreg", dut_m.shreg, 8'h00);
        chk("lsb shreg", dut_l.shreg, 8'h00);
    endtask

    initial begin
        logic [15:0] bb_m, bb_l;

        tbl[0] = '{8'hA5, 8'hA5, 8'hA5, -1, 0};
        tbl[1] = '{8'h3C, 8'h3C, 8'h3C,  2, 3};
        tbl[2] = '{8'hC4, 8'hC4, 8'h23,  7, 2};
        tbl[3] = '{8'h6B, 8'h6B, 8'hD6,  0, 1};
        tbl[4] = '{8'h00, 8'h00, 8'h00, -1, 0};
        tbl[5] = '{8'h81, 8'h81, 8'h81, -1, 0};
        tbl[6] = '{8'h01, 8'h01, 8'h80,  5, 4};

        rst        = 1'b1;
        load_valid = 1'b1;
        shift_en   = 1'b0;
        sin        = 1'b1;
        par_in     = 8'hA5;

        // Reset with a pending request: nothing may be accepted
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'hA5);
            sample("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        send_word(0);

        // shift_en while idle has no effect
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            sample("idle shift", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        for (int k = 1; k < 7; k++) begin
            if (k != 5) send_word(k);
        end

        // Back-to-back: second word handshakes on the last & shift_en cycle
        bb_m = 16'hF00F;
        bb_l = 16'h0FF0;
        drive(1'b0, 1'b1, 1'b0, 8'hF0);
        sample("b2b load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) drive(1'b0, 1'b1, 1'b1, 8'h0F);
            else        drive(1'b0, 1'b0, 1'b1, 8'h0F);
            sample("b2b", bb_m[15-i], bb_l[15-i], 1'b1, (i == 7) || (i == 15), (i == 7) || (i == 15));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        sample("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-word reset discards the word
        drive(1'b0, 1'b1, 1'b0, 8'hFF);
        sample("mid load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'hFF);
            sample("mid bit", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        sample("mid rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        sample("after rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
